// File: rtl/button_debouncer.sv
// Purpose : conditions a raw, bouncing pushbutton into a clean synchronous level,
//           one-cycle rise/fall pulses and a wrapping count of qualified presses.
// Latency : an input change before edge k that then holds shows on button_out at edge k+1+STABLE_CYCLES.
// Backpressure: none; outputs are free-running levels/pulses consumed directly as D or enable inputs.
//
// Ports:
//   clock        system clock, all state updates on the rising edge
//   reset        asynchronous, active-high; clears every register
//   button_in    raw asynchronous button level (never used past the synchronizer)
//   button_out   debounced level
//   rise_pulse   one-cycle pulse on the edge button_out goes 0->1
//   fall_pulse   one-cycle pulse on the edge button_out goes 1->0
//   press_count  number of rise events, modulo 2^PRESS_WIDTH
module button_debouncer #(
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_WIDTH     = 20,
    parameter int PRESS_WIDTH   = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   button_in,
    output logic                   button_out,
    output logic                   rise_pulse,
    output logic                   fall_pulse,
    output logic [PRESS_WIDTH-1:0] press_count
);

    // Terminal count: the sample that completes qualification is the
    // STABLE_CYCLES-th one, seen while the counter holds STABLE_CYCLES-1.
    // Stopping there means the counter can never wrap.
    localparam logic [CNT_WIDTH-1:0]   CNT_LAST  = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [PRESS_WIDTH-1:0] PRESS_ONE = PRESS_WIDTH'(1);

    logic                 sync0;
    logic                 sync1;
    logic [CNT_WIDTH-1:0] stable_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync0       <= 1'b0;
            sync1       <= 1'b0;
            stable_cnt  <= '0;
            button_out  <= 1'b0;
            rise_pulse  <= 1'b0;
            fall_pulse  <= 1'b0;
            press_count <= '0;
        end else begin
            // Two-flop synchronizer; only sync1 is allowed into the logic below.
            sync0 <= button_in;
            sync1 <= sync0;

            // Pulses default low so each one lasts exactly one cycle.
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;

            if (sync1 == button_out) begin
                // Any return to the current level discards partial progress,
                // so counts never accumulate across bounces.
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                button_out <= sync1;
                stable_cnt <= '0;
                // sync1 differs from button_out here, so exactly one of the
                // two pulses fires and they can never coincide.
                rise_pulse <= sync1;
                fall_pulse <= ~sync1;
                if (sync1) begin
                    press_count <= press_count + PRESS_ONE;
                end
            end else begin
                stable_cnt <= stable_cnt + CNT_ONE;
            end
        end
    end

endmodule
